// File: rtl/cpu_dbg_pkg.sv
// Shared encodings and default widths for the CPU run-control block.
package cpu_dbg_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int RST_HOLD_DEF   = 2;
   localparam int WDOG_LIMIT_DEF = 64;
   localparam int PC_W           = 32;
   localparam int CYC_W          = 32;

   typedef enum logic [1:0] {
      OP_HALT = 2'b00,
      OP_RUN  = 2'b01,
      OP_STEP = 2'b10,
      OP_CLR  = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_RSTH = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_e;

endpackage

// File: rtl/dbg_down_counter.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
module dbg_down_counter #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load has priority; decrement stops at zero.
   always_ff @(posedge clk_sys) begin
      if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run-control for MainBoard: drives cpu_rst and the per-cycle cpu_ce from a
// command handshake, with N-cycle step, halt, PC breakpoint and a cycle count.
// Optional stuck-pc watchdog is built when CPU_STEP_WDOG_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RSTH | MainBoard held in reset for RST_HOLD cycles after Reset
// ST_HALT | CPU stopped, commands accepted
// ST_RUN  | free run until breakpoint, HALT command or watchdog
// ST_STEP | run until 'remaining' cycles executed, breakpoint or HALT
module cpu_step_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RST_HOLD   = RST_HOLD_DEF,
   parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [PC_W-1:0]  pc,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   output logic             cpu_rst,
   output logic             cpu_ce,
   output logic [1:0]       state,
   output logic             halted,
   output logic             bp_hit,
`ifdef CPU_STEP_WDOG_EN
   output logic             wdog_hit,
`endif
   output logic [CYC_W-1:0] cycle_cnt
);

   localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

   state_e            state_q, state_nxt;
   cmd_op_e           op;
   logic              cmd_acc, active, bp_match, skip_bp;
   logic              go, step_last, hold_done, wd_trip;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_zero;
   logic [CNT_W-1:0]  rem_cnt;
   logic              rem_zero, rem_load;

   assign op       = cmd_op_e'(cmd_op);
   assign cmd_acc  = cmd_valid && cmd_ready;
   assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign bp_match = active && bp_en && (pc == bp_addr) && !skip_bp;
   assign cpu_ce   = active && !bp_match;
   assign state    = state_q;

   // Accepted RUN, or STEP with a non-zero count, leaving HALT.
   assign go = (state_q == ST_HALT) && cmd_acc &&
               ((op == OP_RUN) || ((op == OP_STEP) && (cmd_steps != '0)));

   // Reset hold: the cycle that sees 1 (or 0 when RST_HOLD is 0) is the last.
   dbg_down_counter #(.W(HOLD_W)) u_hold_cnt (
      .clk_sys  (Clock),
      .load     (Reset),
      .load_val (HOLD_W'(RST_HOLD)),
      .dec      (state_q == ST_RSTH),
      .count    (hold_cnt),
      .zero     (hold_zero)
   );
   assign hold_done = hold_zero || (hold_cnt == HOLD_W'(1));

   assign rem_load = Reset || (go && (op == OP_STEP));

   dbg_down_counter #(.W(CNT_W)) u_rem_cnt (
      .clk_sys  (Clock),
      .load     (rem_load),
      .load_val (Reset ? '0 : cmd_steps),
      .dec      ((state_q == ST_STEP) && cpu_ce && !rem_zero),
      .count    (rem_cnt),
      .zero     (rem_zero)
   );
   assign step_last = (state_q == ST_STEP) && cpu_ce && (rem_cnt == CNT_W'(1));

`ifdef CPU_STEP_WDOG_EN
   localparam int WD_W = $clog2(WDOG_LIMIT + 1);

   logic [WD_W-1:0] wd_cnt, wd_nxt;
   logic [PC_W-1:0] prev_pc;

   // First executed cycle at a pc counts as 1; each repeat adds one.
   always_comb begin
      wd_nxt = WD_W'(1);
      if ((wd_cnt != '0) && (pc == prev_pc))
         wd_nxt = wd_cnt + 1'b1;
   end
   assign wd_trip = cpu_ce && (wd_nxt == WD_W'(WDOG_LIMIT));

   // Stuck-pc run length, cleared whenever the CPU is not running.
   always_ff @(posedge Clock) begin
      if (Reset || !active)
         wd_cnt <= '0;
      else if (cpu_ce)
         wd_cnt <= wd_nxt;
      if (Reset)
         prev_pc <= '0;
      else if (cpu_ce)
         prev_pc <= pc;
   end

   // Sticky watchdog flag, cleared by the next RUN/STEP launch.
   always_ff @(posedge Clock) begin
      if (Reset)
         wdog_hit <= 1'b0;
      else if (go)
         wdog_hit <= 1'b0;
      else if (wd_trip)
         wdog_hit <= 1'b1;
   end
`else
   assign wd_trip = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RSTH: if (hold_done) state_nxt = ST_HALT;
         ST_HALT: begin
            if (go) state_nxt = (op == OP_RUN) ? ST_RUN : ST_STEP;
         end
         default: begin
            if (bp_match || step_last || wd_trip || (cmd_acc && (op == OP_HALT)))
               state_nxt = ST_HALT;
         end
      endcase
      if (Reset)
         state_nxt = ST_RSTH;
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge Clock) begin
      state_q   <= state_nxt;
      cpu_rst   <= (state_nxt == ST_RSTH);
      cmd_ready <= (state_nxt != ST_RSTH);
      halted    <= (state_nxt == ST_HALT);
   end

   // Breakpoint skip for the first executed cycle after launch, and sticky hit.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         skip_bp <= 1'b0;
         bp_hit  <= 1'b0;
      end else if (go) begin
         skip_bp <= 1'b1;
         bp_hit  <= 1'b0;
      end else begin
         if (cpu_ce)
            skip_bp <= 1'b0;
         if (bp_match)
            bp_hit <= 1'b1;
      end
   end

   // Executed-cycle counter; a clear in the same cycle as an increment wins.
   always_ff @(posedge Clock) begin
      if (Reset)
         cycle_cnt <= '0;
      else if (cmd_acc && (op == OP_CLR))
         cycle_cnt <= '0;
      else if (cpu_ce)
         cycle_cnt <= cycle_cnt + 1'b1;
   end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: expected per-cycle ce/rst/state pushed to a queue
// as commands are issued, popped and compared each cycle.
module tb_cpu_step_ctrl;
   import cpu_dbg_pkg::*;

   localparam int CNT_W = 16;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_steps;
   logic [31:0]      pc;
   logic             bp_en;
   logic [31:0]      bp_addr;
   logic             cpu_rst;
   logic             cpu_ce;
   logic [1:0]       state;
   logic             halted;
   logic             bp_hit;
   logic [31:0]      cycle_cnt;
`ifdef CPU_STEP_WDOG_EN
   logic             wdog_hit;
`endif

   always #5 Clock = ~Clock;

`ifdef CPU_STEP_WDOG_EN
   cpu_step_ctrl #(.CNT_W(CNT_W), .RST_HOLD(2), .WDOG_LIMIT(4)) dut (
`else
   cpu_step_ctrl #(.CNT_W(CNT_W), .RST_HOLD(2)) dut (
`endif
      .Clock     (Clock),
      .Reset     (Reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_steps (cmd_steps),
      .pc        (pc),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .cpu_rst   (cpu_rst),
      .cpu_ce    (cpu_ce),
      .state     (state),
      .halted    (halted),
      .bp_hit    (bp_hit),
`ifdef CPU_STEP_WDOG_EN
      .wdog_hit  (wdog_hit),
`endif
      .cycle_cnt (cycle_cnt)
   );

   typedef struct packed {
      logic       ce;
      logic       rst;
      logic [1:0] st;
   } exp_t;

   exp_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   string cur      = "init";
   logic  pc_stuck = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s.%s got=%h exp=%h", cur, tag, got, exp);
      end
   endtask

   task automatic expect_cy(input logic ce, input logic rst, input state_e st, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({ce, rst, 2'(st)});
   endtask

   // One clock: compare at the falling edge, then advance the pc like MainBoard.
   task automatic cycle();
      exp_t e;
      logic ce_s;
      @(negedge Clock);
      ce_s = cpu_ce;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ce",    32'(cpu_ce),  32'(e.ce));
         chk("rst",   32'(cpu_rst), 32'(e.rst));
         chk("state", 32'(state),   32'(e.st));
      end
      @(posedge Clock);
      #1;
      if (ce_s && !pc_stuck)
         pc = pc + 32'd4;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++)
         cycle();
   endtask

   task automatic cmd(input logic [1:0] op, input logic [CNT_W-1:0] n);
      chk("ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_steps = n;
      cycle();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_steps = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      Reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_steps = '0;
      pc        = 32'h0;
      bp_en     = 1'b0;
      bp_addr   = 32'h0;

      cur = "reset";
      expect_cy(1'b0, 1'b1, ST_RSTH, 3);
      cycles(3);
      chk("ready", 32'(cmd_ready), 32'd0);
      chk("halted", 32'(halted), 32'd0);
      chk("cnt", cycle_cnt, 32'd0);
      Reset = 1'b0;
      expect_cy(1'b0, 1'b1, ST_RSTH, 2);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cycles(3);
      chk("halted", 32'(halted), 32'd1);
      chk("cnt", cycle_cnt, 32'd0);
      chk("bp_hit", 32'(bp_hit), 32'd0);

      cur = "step5";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_STEP, 5);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_STEP, 16'd5);
      cycles(6);
      chk("cnt", cycle_cnt, 32'd5);
      chk("halted", 32'(halted), 32'd1);

      cur = "step0";
      expect_cy(1'b0, 1'b0, ST_HALT, 2);
      cmd(OP_STEP, 16'd0);
      cycle();
      chk("cnt", cycle_cnt, 32'd5);

      cur = "bp";
      pc      = 32'h0;
      bp_en   = 1'b1;
      bp_addr = 32'h0000_000C;
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 3);
      expect_cy(1'b0, 1'b0, ST_RUN, 1);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      cycles(5);
      chk("bp_hit", 32'(bp_hit), 32'd1);
      chk("cnt", cycle_cnt, 32'd8);
      chk("pc", pc, 32'h0000_000C);

      cur = "bp_rerun";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 3);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      chk("bp_hit", 32'(bp_hit), 32'd0);
      cycles(2);
      cmd(OP_HALT, 16'd0);
      cycle();
      chk("cnt", cycle_cnt, 32'd11);

      cur = "bp_and_halt";
      bp_addr = pc + 32'd4;
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 1);
      expect_cy(1'b0, 1'b0, ST_RUN, 1);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      cycle();
      cmd(OP_HALT, 16'd0);
      cycle();
      chk("bp_hit", 32'(bp_hit), 32'd1);
      chk("cnt", cycle_cnt, 32'd12);
      bp_en = 1'b0;

      cur = "halt7";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 7);
      expect_cy(1'b0, 1'b0, ST_HALT, 3);
      cmd(OP_RUN, 16'd0);
      cycles(6);
      cmd(OP_HALT, 16'd0);
      cycles(3);
      chk("cnt", cycle_cnt, 32'd19);
      cmd(OP_CLR, 16'd0);
      chk("cnt_clr", cycle_cnt, 32'd0);
      chk("halted", 32'(halted), 32'd1);

      cur = "clr_inc";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 4);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      cmd(OP_RUN, 16'd0);
      cycle();
      chk("cnt", cycle_cnt, 32'd2);
      cmd(OP_CLR, 16'd0);
      chk("cnt_clr", cycle_cnt, 32'd0);
      cmd(OP_HALT, 16'd0);
      cycle();
      chk("cnt", cycle_cnt, 32'd1);

      cur = "wrap";
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      cycle();
      release dut.cycle_cnt;
      cycle();
      chk("preload", cycle_cnt, 32'hFFFF_FFFE);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 3);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      cycles(2);
      cmd(OP_HALT, 16'd0);
      cycle();
      chk("cnt", cycle_cnt, 32'h0000_0001);

      cur = "rst_mid_step";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_STEP, 4);
      expect_cy(1'b0, 1'b1, ST_RSTH, 2);
      expect_cy(1'b0, 1'b0, ST_HALT, 4);
      cmd(OP_STEP, 16'd100);
      cycles(3);
      Reset = 1'b1;
      cycle();
      Reset = 1'b0;
      cycles(6);
      chk("cnt", cycle_cnt, 32'd0);
      chk("halted", 32'(halted), 32'd1);

      cur = "step1";
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_STEP, 1);
      expect_cy(1'b0, 1'b0, ST_HALT, 2);
      cmd(OP_STEP, 16'd1);
      cycles(3);
      chk("cnt", cycle_cnt, 32'd1);

`ifdef CPU_STEP_WDOG_EN
      cur = "wdog";
      pc_stuck = 1'b1;
      pc       = 32'h0000_0020;
      chk("wdog_hit", 32'(wdog_hit), 32'd0);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      expect_cy(1'b1, 1'b0, ST_RUN, 4);
      expect_cy(1'b0, 1'b0, ST_HALT, 1);
      cmd(OP_RUN, 16'd0);
      cycles(5);
      chk("wdog_hit", 32'(wdog_hit), 32'd1);
      chk("cnt", cycle_cnt, 32'd5);
      pc_stuck = 1'b0;
`endif

      cur = "end";
      chk("queue_left", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
